game_frame_sequencer: RTL and testbench



---
 rtl/game_frame_sequencer_pkg.sv | 20 ++
 rtl/game_frame_sequencer_phase_watchdog.sv | 36 +++
 rtl/game_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_game_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_frame_sequencer_pkg.sv
// Shared encodings and defaults for the game frame sequencer and its watchdog.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_PLAY  = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_PHYS   = 2'd1,
    S_SCROLL = 2'd2,
    S_COLL   = 2'd3
  } seq_state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/game_frame_sequencer_phase_watchdog.sv
// Loadable up-counter that flags a unit which has not answered within TIMEOUT_CYC cycles.
module phase_watchdog
  import game_pkg::*;
#(
  parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_reg;

  // Holds at the limit so a late clear cannot race a wrapped count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/game_frame_sequencer.sv
// Per-frame scheduler: runs physics, scroll and collision in order on each game tick and
// owns the top-level game state. Pause support is compiled in when GAME_PAUSE_EN is defined.
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int FRAME_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               btn_start,
  input  logic               btn_pause,
  output logic               phys_start,
  input  logic               phys_done,
  output logic               scroll_start,
  input  logic               scroll_done,
  output logic               coll_start,
  input  logic               coll_done,
  input  logic               collision,
  output logic               frame_done,
  output logic [1:0]         game_state,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  game_state_t        game_state_reg, game_state_next;
  seq_state_t         seq_state_reg, seq_state_next;
  logic               phys_start_reg, phys_start_next;
  logic               scroll_start_reg, scroll_start_next;
  logic               coll_start_reg, coll_start_next;
  logic               frame_done_reg, frame_done_next;
  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic               overrun_reg, overrun_next;
  logic               timeout_err_reg, timeout_err_next;
  logic               wd_load, wd_clear, wd_en, wd_expired;
  logic               pause_take, pause_resume;

`ifdef GAME_PAUSE_EN
  logic pause_req_reg, pause_req_next;

  always_ff @(posedge clk) begin
    if (rst) pause_req_reg <= 1'b0;
    else     pause_req_reg <= pause_req_next;
  end

  always_comb begin
    pause_req_next = pause_req_reg;
    if (game_state_reg != GS_PLAY) pause_req_next = 1'b0;
    else if (btn_pause)            pause_req_next = 1'b1;
  end

  // A request only takes effect between frames, so an in-flight frame always finishes.
  assign pause_take   = pause_req_reg || btn_pause;
  assign pause_resume = btn_pause;
`else
  logic unused_btn_pause;
  assign unused_btn_pause = btn_pause;
  assign pause_take       = 1'b0;
  assign pause_resume     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      game_state_reg   <= GS_IDLE;
      seq_state_reg    <= S_WAIT;
      phys_start_reg   <= 1'b0;
      scroll_start_reg <= 1'b0;
      coll_start_reg   <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_cnt_reg    <= '0;
      overrun_reg      <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      game_state_reg   <= game_state_next;
      seq_state_reg    <= seq_state_next;
      phys_start_reg   <= phys_start_next;
      scroll_start_reg <= scroll_start_next;
      coll_start_reg   <= coll_start_next;
      frame_done_reg   <= frame_done_next;
      frame_cnt_reg    <= frame_cnt_next;
      overrun_reg      <= overrun_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  always_comb begin
    game_state_next   = game_state_reg;
    seq_state_next    = seq_state_reg;
    phys_start_next   = 1'b0;
    scroll_start_next = 1'b0;
    coll_start_next   = 1'b0;
    frame_done_next   = 1'b0;
    frame_cnt_next    = frame_cnt_reg;
    overrun_next      = overrun_reg;
    timeout_err_next  = timeout_err_reg;
    wd_load           = 1'b0;

    case (game_state_reg)
      GS_IDLE: begin
        seq_state_next = S_WAIT;
        if (btn_start) begin
          game_state_next  = GS_PLAY;
          frame_cnt_next   = '0;
          overrun_next     = 1'b0;
          timeout_err_next = 1'b0;
        end
      end
      GS_PLAY: begin
        if (game_tick && seq_state_reg != S_WAIT) overrun_next = 1'b1;
        case (seq_state_reg)
          S_WAIT: begin
            if (pause_take) begin
              game_state_next = GS_PAUSE;
            end else if (game_tick) begin
              phys_start_next = 1'b1;
              seq_state_next  = S_PHYS;
              wd_load         = 1'b1;
            end
          end
          S_PHYS: begin
            if (phys_done) begin
              scroll_start_next = 1'b1;
              seq_state_next    = S_SCROLL;
              wd_load           = 1'b1;
            end else if (wd_expired) begin
              timeout_err_next = 1'b1;
              seq_state_next   = S_WAIT;
            end
          end
          S_SCROLL: begin
            if (scroll_done) begin
              coll_start_next = 1'b1;
              seq_state_next  = S_COLL;
              wd_load         = 1'b1;
            end else if (wd_expired) begin
              timeout_err_next = 1'b1;
              seq_state_next   = S_WAIT;
            end
          end
          S_COLL: begin
            if (coll_done) begin
              frame_done_next = 1'b1;
              frame_cnt_next  = frame_cnt_reg + FRAME_W'(1);
              seq_state_next  = S_WAIT;
              if (collision) game_state_next = GS_OVER;
            end else if (wd_expired) begin
              timeout_err_next = 1'b1;
              seq_state_next   = S_WAIT;
            end
          end
          default: seq_state_next = S_WAIT;
        endcase
      end
      GS_PAUSE: begin
        seq_state_next = S_WAIT;
        if (pause_resume) game_state_next = GS_PLAY;
      end
      GS_OVER: begin
        seq_state_next = S_WAIT;
        if (btn_start) game_state_next = GS_IDLE;
      end
      default: game_state_next = GS_IDLE;
    endcase
  end

  // The start cycle itself counts as the first waiting cycle, hence the load value of 1.
  assign wd_en    = (game_state_reg == GS_PLAY) && (seq_state_reg != S_WAIT);
  assign wd_clear = (seq_state_reg == S_WAIT);

  phase_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .load      (wd_load),
    .load_value(WD_W'(1)),
    .en        (wd_en),
    .expired   (wd_expired)
  );

  assign phys_start   = phys_start_reg;
  assign scroll_start = scroll_start_reg;
  assign coll_start   = coll_start_reg;
  assign frame_done   = frame_done_reg;
  assign game_state   = game_state_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign overrun      = overrun_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Randomized scoreboard bench for game_frame_sequencer; frames are planned as transactions.
`timescale 1ns/1ps
module tb_game_frame_sequencer;

  localparam int TMO = 10;
  localparam int FW  = 4;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_PAUSE = 2, ST_OVER = 3;
  localparam int EV_PHYS = 0, EV_SCROLL = 1, EV_COLL = 2, EV_FRAME = 3;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_BUILD = 1'b1;
`else
  localparam bit PAUSE_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          game_tick = 1'b0, btn_start = 1'b0, btn_pause = 1'b0;
  logic          phys_done = 1'b0, scroll_done = 1'b0, coll_done = 1'b0, collision = 1'b0;
  logic          phys_start, scroll_start, coll_start, frame_done, overrun, timeout_err;
  logic [1:0]    game_state;
  logic [FW-1:0] frame_cnt;

  game_frame_sequencer #(
    .TIMEOUT_CYC(TMO),
    .FRAME_W    (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_tick   (game_tick),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .phys_start  (phys_start),
    .phys_done   (phys_done),
    .scroll_start(scroll_start),
    .scroll_done (scroll_done),
    .coll_start  (coll_start),
    .coll_done   (coll_done),
    .collision   (collision),
    .frame_done  (frame_done),
    .game_state  (game_state),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
    int cnt;
    int st;
    int ovr;
    int tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Transaction-level reference model of the externally visible state.
  int m_cnt = 0, m_state = ST_IDLE, m_ovr = 0, m_tmo = 0;

  function automatic string ev_name(input int kind);
    case (kind)
      EV_PHYS:   return "phys_start";
      EV_SCROLL: return "scroll_start";
      EV_COLL:   return "coll_start";
      default:   return "frame_done";
    endcase
  endfunction

  function automatic bit rnd();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind; e.at = at; e.cnt = m_cnt; e.st = m_state; e.ovr = m_ovr; e.tmo = m_tmo;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected %s: got pulse at cycle %0d, required none", ev_name(kind), cyc);
      return;
    end
    e = exp_q.pop_front();
    check({ev_name(kind), " kind"}, kind, e.kind);
    check({ev_name(kind), " cycle"}, cyc, e.at);
    if (kind == EV_FRAME) begin
      check("frame_done frame_cnt", int'(frame_cnt), e.cnt);
      check("frame_done game_state", int'(game_state), e.st);
      check("frame_done overrun", int'(overrun), e.ovr);
      check("frame_done timeout_err", int'(timeout_err), e.tmo);
      $display("frame_done cycle %0d frame_cnt %0d game_state %0d", cyc, frame_cnt, game_state);
    end
  endtask

  // Monitor: every start strobe or frame_done must match the next planned event.
  always @(negedge clk) begin
    if (phys_start)   expect_event(EV_PHYS);
    if (scroll_start) expect_event(EV_SCROLL);
    if (coll_start)   expect_event(EV_COLL);
    if (frame_done)   expect_event(EV_FRAME);
  end

  // One call = one clock cycle of stimulus; outputs read afterwards belong to that cycle.
  task automatic drive(input bit tk, pd, sd, cd, cl, bs, bp);
    @(posedge clk);
    #1;
    game_tick = tk; phys_done = pd; scroll_done = sd; coll_done = cd;
    collision = cl; btn_start = bs; btn_pause = bp;
  endtask

  task automatic idle1();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One unit phase: cycles start..start+d, done on the last; optional strays and extra ticks.
  task automatic phase(input int which, input int d, input bit noise, input bit col,
                       input bit xt_first, input bit bp_first);
    bit tk, pd, sd, cd, cl, bs, bp;
    for (int k = 0; k <= d; k++) begin
      tk = (xt_first && k == 0) || (noise && $urandom_range(0, 3) == 0);
      bs = noise && rnd();
      bp = bp_first && k == 0;
      pd = 1'b0; sd = 1'b0; cd = 1'b0; cl = 1'b0;
      if (k == d) begin
        pd = (which == 0); sd = (which == 1); cd = (which == 2); cl = (which == 2) && col;
      end else if (noise) begin
        pd = (which != 0) && rnd();
        sd = (which != 1) && rnd();
        cd = (which != 2) && rnd();
        cl = rnd();
      end
      if (tk) m_ovr = 1;
      drive(tk, pd, sd, cd, cl, bs, bp);
    end
  endtask

  task automatic run_frame(input int d1, d2, d3, input bit col, noise, xt_scroll, bp_phys);
    drive(1, 0, 0, 0, 0, 0, 0);
    push(EV_PHYS, cyc + 1);
    phase(0, d1, noise, 1'b0, 1'b0, bp_phys);
    push(EV_SCROLL, cyc + 1);
    phase(1, d2, noise, 1'b0, xt_scroll, 1'b0);
    push(EV_COLL, cyc + 1);
    phase(2, d3, noise, col, 1'b0, 1'b0);
    m_cnt = (m_cnt + 1) % (1 << FW);
    if (col) m_state = ST_OVER;
    push(EV_FRAME, cyc + 1);
  endtask

  // Idle cycles between frames: only inputs that must be ignored in the current state.
  task automatic gap(input int n, input bit noise);
    bit tk, bs, bp;
    for (int i = 0; i < n; i++) begin
      tk = (m_state != ST_PLAY) && noise && rnd();
      bs = (m_state == ST_PLAY || m_state == ST_PAUSE) && noise && rnd();
      bp = !PAUSE_BUILD && noise && rnd();
      drive(tk, noise && rnd(), noise && rnd(), noise && rnd(), rnd(), bs, bp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got no finish by 500 us, required finish");
    $fatal(1);
  end

  initial begin
    int s;

    repeat (3) idle1();
    check("reset game_state", int'(game_state), ST_IDLE);
    check("reset frame_cnt", int'(frame_cnt), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset timeout_err", int'(timeout_err), 0);
    check("reset phys_start", int'(phys_start), 0);
    check("reset frame_done", int'(frame_done), 0);
    rst = 1'b0;

    gap(3, 1'b1);
    drive(1, 0, 0, 0, 0, 1, 0);  // start and tick together: tick unused
    m_state = ST_PLAY; m_cnt = 0; m_ovr = 0; m_tmo = 0;
    idle1();
    check("start enters PLAY", int'(game_state), ST_PLAY);
    gap(2, 1'b0);

    run_frame(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle1();
    check("frame_cnt after first frame", int'(frame_cnt), m_cnt);

    run_frame(2, 3, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle1();
    check("overrun after tick in scroll", int'(overrun), 1);

    gap(1, 1'b1);
    run_frame(1, TMO - 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle1();
    check("no timeout at last legal cycle", int'(timeout_err), 0);

    // Scroll unit hangs: timeout exactly TMO cycles after scroll_start, frame aborted.
    drive(1, 0, 0, 0, 0, 0, 0);
    push(EV_PHYS, cyc + 1);
    phase(0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    s = cyc + 1;
    push(EV_SCROLL, s);
    for (int k = 0; k < TMO; k++) idle1();
    check("timeout_err one cycle early", int'(timeout_err), 0);
    idle1();
    check("timeout_err at limit", int'(timeout_err), 1);
    check("cycles from scroll_start to timeout", cyc - s, TMO);
    m_tmo = 1;
    check("game_state after timeout", int'(game_state), ST_PLAY);
    run_frame(2, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 18; f++) begin
      run_frame($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5),
                1'b0, 1'b1, 1'b0, 1'b0);
      gap($urandom_range(0, 3), 1'b1);
    end

    run_frame(1, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle1();
    check("collision leads to OVER", int'(game_state), ST_OVER);
    gap(4, 1'b1);
    drive(0, 0, 0, 0, 0, 1, 0);
    m_state = ST_IDLE;
    idle1();
    check("start in OVER returns to IDLE", int'(game_state), ST_IDLE);
    check("frame_cnt kept in IDLE", int'(frame_cnt), m_cnt);
    drive(0, 0, 0, 0, 0, 1, 0);
    m_state = ST_PLAY; m_cnt = 0; m_ovr = 0; m_tmo = 0;
    idle1();
    check("restart game_state", int'(game_state), ST_PLAY);
    check("restart frame_cnt cleared", int'(frame_cnt), 0);
    check("restart overrun cleared", int'(overrun), 0);
    check("restart timeout_err cleared", int'(timeout_err), 0);

`ifdef GAME_PAUSE_EN
    run_frame(2, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle1();
    idle1();
    check("pause after in-flight frame", int'(game_state), ST_PAUSE);
    m_state = ST_PAUSE;
    for (int t = 0; t < 5; t++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      idle1();
    end
    check("ticks in PAUSE leave overrun", int'(overrun), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    m_state = ST_PLAY;
    idle1();
    check("resume to PLAY", int'(game_state), ST_PLAY);
    run_frame(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 1);
    idle1();
    check("pause beats tick", int'(game_state), ST_PAUSE);
    check("pause with tick no overrun", int'(overrun), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    m_state = ST_PLAY;
    idle1();
    check("second resume to PLAY", int'(game_state), ST_PLAY);
`endif

    run_frame(1, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle1();
    check("overrun before mid-frame reset", int'(overrun), 1);

    // Reset in the cycle phys_done arrives: no scroll_start, everything back to reset values.
    drive(1, 0, 0, 0, 0, 0, 0);
    push(EV_PHYS, cyc + 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle1();
    rst = 1'b0;
    m_state = ST_IDLE; m_cnt = 0; m_ovr = 0; m_tmo = 0;
    check("mid-frame reset game_state", int'(game_state), ST_IDLE);
    check("mid-frame reset frame_cnt", int'(frame_cnt), 0);
    check("mid-frame reset overrun", int'(overrun), 0);
    check("mid-frame reset scroll_start", int'(scroll_start), 0);
    gap(3, 1'b1);
    repeat (2) idle1();

    check("pending expected events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
